add64_sequencer: RTL



---
 rtl/add64_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/add64_sequencer.sv
// rtl/add64_sequencer.sv - multi-word add sequencer driving an external WIDTH-bit combinational adder
module add64_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH*WORDS-1:0]   op_a,
    input  logic [WIDTH*WORDS-1:0]   op_b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   result,
    output logic                     cout,
    output logic                     overflow,
    output logic                     zero,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    output logic                     adder_cin,
    input  logic [WIDTH-1:0]         adder_sum,
    input  logic                     adder_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       state;
    logic [WORDS-1:0][WIDTH-1:0]  a_w;
    logic [WORDS-1:0][WIDTH-1:0]  b_w;
    logic [WORDS-1:0][WIDTH-1:0]  sum_w;
    logic [WORDS-1:0][WIDTH-1:0]  sum_nxt;
    logic [IDXW-1:0]              idx;
    logic [IDXW-1:0]              idx_inc;
    logic                         carry;
    logic                         ovf_nxt;

    // The carry register is what the adder sees as its carry-in
    assign adder_cin = carry;
    assign idx_inc   = idx + 1'b1;

    // Working sum with the word currently at the adder merged in; the final
    // edge of an operation stores this straight into result
    always_comb begin
        sum_nxt      = sum_w;
        sum_nxt[idx] = adder_sum;
        ovf_nxt      = (a_w[WORDS-1][WIDTH-1] == b_w[WORDS-1][WIDTH-1]) &&
                       (sum_nxt[WORDS-1][WIDTH-1] != a_w[WORDS-1][WIDTH-1]);
    end

    // Sequencer FSM: latch operands, step one word per clock, publish flags on the last word
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            adder_a  <= '0;
            adder_b  <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            a_w      <= '0;
            b_w      <= '0;
            sum_w    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Word 0 goes to the adder on the same edge the operands are latched
                        a_w     <= op_a;
                        b_w     <= op_b;
                        sum_w   <= '0;
                        idx     <= '0;
                        carry   <= cin;
                        adder_a <= op_a[WIDTH-1:0];
                        adder_b <= op_b[WIDTH-1:0];
                        busy    <= 1'b1;
                        state   <= S_ADD;
                    end else begin
                        adder_a <= '0;
                        adder_b <= '0;
                        carry   <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_ADD: begin
                    // start is deliberately not looked at here: operands in flight stay put
                    sum_w <= sum_nxt;
                    if (idx == LAST_IDX) begin
                        result   <= sum_nxt;
                        cout     <= adder_cout;
                        overflow <= ovf_nxt;
                        zero     <= ~|sum_nxt;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        idx      <= '0;
                        adder_a  <= '0;
                        adder_b  <= '0;
                        carry    <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        idx     <= idx_inc;
                        adder_a <= a_w[idx_inc];
                        adder_b <= b_w[idx_inc];
                        carry   <= adder_cout;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    adder_a <= '0;
                    adder_b <= '0;
                    carry   <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
